// File: rtl/mmio_timer.sv
// mmio_timer: bus-responder timer peripheral occupying a 16-byte window.
// Registers: CTRL (0x0), COUNT (0x4), COMPARE (0x8), STATUS (0xC, W1C).
// A prescaled 32-bit up-counter sets MATCH when it equals COMPARE and OVF
// when it wraps. Irq is a registered level request gated by CTRL.IE.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        Wr,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        Hit,
  output logic        Irq
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  // Architectural state
  logic        en, auto_clr, ie;
  logic [7:0]  presc;
  logic [7:0]  pc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match, ovf;

  // Decode
  logic     hit_now, word_ok, wr_ok;
  reg_sel_e sel;
  logic     wr_ctrl, wr_count, wr_compare, wr_status;

  // Next-state values
  logic        en_next, auto_next, ie_next;
  logic [7:0]  presc_next;
  logic [7:0]  pc_next;
  logic [31:0] count_next, compare_next;
  logic        match_set, ovf_set;
  logic        match_next, ovf_next;
  logic [31:0] rd_data;

  logic tick, at_compare, at_max;

  // Address decode: window hit, word alignment and per-register write strobes
  always_comb begin
    hit_now    = (Address[31:4] == BASE_ADDR[31:4]);
    word_ok    = (Address[1:0] == 2'b00);
    sel        = reg_sel_e'(Address[3:2]);
    wr_ok      = Wr & hit_now & word_ok;
    wr_ctrl    = wr_ok & (sel == REG_CTRL);
    wr_count   = wr_ok & (sel == REG_COUNT);
    wr_compare = wr_ok & (sel == REG_COMPARE);
    wr_status  = wr_ok & (sel == REG_STATUS);
  end

  assign tick       = en & (pc == presc);
  assign at_compare = (count == compare);
  assign at_max     = &count;

  // Next-state computation for control, prescaler, counter and flags
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left one unassigned would infer a latch.
    en_next      = en;
    auto_next    = auto_clr;
    ie_next      = ie;
    presc_next   = presc;
    compare_next = compare;
    pc_next      = pc;
    count_next   = count;
    match_set    = 1'b0;
    ovf_set      = 1'b0;

    if (wr_ctrl) begin
      en_next    = Datain[0];
      auto_next  = Datain[1];
      ie_next    = Datain[2];
      presc_next = Datain[15:8];
    end

    if (wr_compare) begin
      compare_next = Datain;
    end

    // Software writes to CTRL or COUNT restart the prescale period.
    if (wr_ctrl || wr_count) begin
      pc_next = 8'd0;
    end else if (en) begin
      pc_next = tick ? 8'd0 : pc + 8'd1;
    end

    // A CPU write to COUNT wins over a tick in the same cycle.
    if (wr_count) begin
      count_next = Datain;
    end else if (tick) begin
      if (at_compare) begin
        match_set = 1'b1;
        if (auto_clr) begin
          count_next = 32'd0;
        end else begin
          count_next = count + 32'd1;
          ovf_set    = at_max;
        end
      end else begin
        count_next = count + 32'd1;
        ovf_set    = at_max;
      end
    end

    // Hardware set beats a write-1-to-clear of the same bit.
    match_next = match_set | (match & ~(wr_status & Datain[0]));
    ovf_next   = ovf_set   | (ovf   & ~(wr_status & Datain[1]));
  end

  // Read mux over pre-write register contents
  always_comb begin
    rd_data = 32'd0;
    if (hit_now && word_ok) begin
      case (sel)
        REG_CTRL:    rd_data = {16'd0, presc, 5'd0, ie, auto_clr, en};
        REG_COUNT:   rd_data = count;
        REG_COMPARE: rd_data = compare;
        REG_STATUS:  rd_data = {30'd0, ovf, match};
      endcase
    end
  end

  // State and registered bus outputs with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      en       <= 1'b0;
      auto_clr <= 1'b0;
      ie       <= 1'b0;
      presc    <= 8'd0;
      pc       <= 8'd0;
      count    <= 32'd0;
      compare  <= 32'd0;
      match    <= 1'b0;
      ovf      <= 1'b0;
      Dataout  <= 32'd0;
      Hit      <= 1'b0;
      Irq      <= 1'b0;
    end else begin
      en       <= en_next;
      auto_clr <= auto_next;
      ie       <= ie_next;
      presc    <= presc_next;
      pc       <= pc_next;
      count    <= count_next;
      compare  <= compare_next;
      match    <= match_next;
      ovf      <= ovf_next;
      Dataout  <= rd_data;
      Hit      <= hit_now;
      Irq      <= ie_next & (match_next | ovf_next);
    end
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral that answers the CPU's data-memory bus: it is the responder side of the address/write-enable/data interface the multicycle CPU drives toward memory. It decodes a 16-byte window and exposes CTRL, COUNT, COMPARE and STATUS registers. It runs a prescaled 32-bit up-counter with compare match and wrap-around overflow, and raises a level interrupt request. The top level ORs its read data into the memory data-out path when `Hit` is high.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FF00: byte address of the window; must be 16-byte aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; one clock is sufficient.
- `Address` in 32: byte address from the CPU address mux.
- `Wr` in 1: write strobe, same meaning as the memory `Wr`.
- `Datain` in 32: write data.
- `Dataout` out 32: registered read data; zero when the previous cycle missed the window.
- `Hit` out 1: registered; 1 when the previous cycle's `Address` was inside the window.
- `Irq` out 1: registered level interrupt request.

## Operation
- Decode:
  - Hit when `Address[31:4] == BASE_ADDR[31:4]`.
  - Register select is `Address[3:2]`: 0 = CTRL, 1 = COUNT, 2 = COMPARE, 3 = STATUS.
  - When `Address[1:0] != 0`, writes are ignored and reads return 0, but `Hit` is still asserted.
- CTRL fields:
  - [0] EN.
  - [1] AUTO: clear COUNT on match.
  - [2] IE: interrupt enable.
  - [15:8] PRESC.
  - Other bits read 0 and ignore writes.
- Prescaler: an internal 8-bit counter PC.
  - When EN = 1 and PC == PRESC, a tick occurs and PC becomes 0; otherwise PC increments.
  - PRESC = 0 gives a tick every cycle.
  - When EN = 0, PC holds.
- On a tick:
  - If COUNT == COMPARE: set STATUS[0] MATCH. COUNT becomes 0 if AUTO is set, otherwise COUNT + 1.
  - Otherwise, COUNT becomes COUNT + 1.
  - When COUNT goes from 32'hFFFF_FFFF to 0 by increment, set STATUS[1] OVF.
- STATUS is write-1-to-clear on bits [1:0]; other bits read 0.
- Read data:
  - CTRL, COUNT and COMPARE return their stored values.
  - STATUS returns {30'b0, OVF, MATCH}.
- `Irq` next = IE & (MATCH | OVF), using the post-update register values.
- Precedence within one cycle:
  - A CPU write to COUNT overrides a tick.
  - A write to COUNT or CTRL clears PC to 0.
  - A hardware set of MATCH/OVF overrides a W1C clear of the same bit in the same cycle.
- The COMPARE write takes effect for comparisons from the next cycle.

## Timing
- Reset:
  - CTRL, COUNT, COMPARE, STATUS and PC are 0.
  - `Dataout` = 0, `Hit` = 0, `Irq` = 0.
- Write: sampled on the edge where `Wr` = 1 and the address hits; the register shows the new value from the next cycle.
- Read latency is 1 cycle, matching the memory: `Address` at edge N gives `Dataout`/`Hit` after edge N+1.
  - Read data reflects register contents before any write in the same cycle.
- A read with `Wr` = 1 still updates `Dataout` (old value) and `Hit`.
- Tick-to-flag latency: MATCH/OVF is visible after the tick edge; `Irq` rises after the same edge.
- Reset mid-count discards all state; counting resumes only after software sets EN.

## Test plan
- Reset, then read all 4 offsets: `Dataout` = 0 for each, `Hit` = 1 one cycle later; `Irq` = 0.
- Write COMPARE = 5, then CTRL = 32'h0000_0007 (EN, AUTO, IE, PRESC = 0):
  - MATCH sets and `Irq` = 1 six ticks after EN.
  - COUNT reads 0, 1, … 5, 0.
- Write CTRL = 32'h0000_0301 (PRESC = 3, EN): COUNT increments once every 4 cycles; after 40 cycles COUNT = 10.
- Write COUNT = 32'hFFFF_FFFE with COMPARE = 0 and CTRL = 1:
  - After 2 ticks COUNT = 0 and OVF = 1.
  - On the following tick MATCH = 1.
  - Writing STATUS = 3 clears both bits; `Irq` = 0 when IE = 0 throughout.
- W1C of MATCH on the same cycle a new match fires: MATCH stays 1.
- COUNT write of 32'h100 coinciding with a tick: COUNT reads 32'h100, not 32'h101.
- Address 32'h0000_0040: `Hit` = 0, `Dataout` = 0, no register changes on a write.
- Address BASE_ADDR + 1: write ignored, read returns 0, `Hit` = 1.
